// File: rtl/xgmii_rx_link_fault_ctrl_if.sv
// XGMII receive datapath bundle: PCS-side input column and frame-receiver-side output column.
// The PCS/testbench drives through master; the link-fault controller uses slave.
interface xgmii_rx_link_fault_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] xgmii_rxd_in;
    logic [CTRL_WIDTH-1:0] xgmii_rxc_in;
    logic [DATA_WIDTH-1:0] xgmii_rxd_out;
    logic [CTRL_WIDTH-1:0] xgmii_rxc_out;

    modport master (
        output xgmii_rxd_in,
        output xgmii_rxc_in,
        input  xgmii_rxd_out,
        input  xgmii_rxc_out
    );

    modport slave (
        input  xgmii_rxd_in,
        input  xgmii_rxc_in,
        output xgmii_rxd_out,
        output xgmii_rxc_out
    );
endinterface

// File: rtl/xgmii_rx_link_fault_ctrl.sv
// Link-fault sequencing for the 32-bit XGMII receive path: detects local/remote
// fault ordered sets, gates the datapath to idle while faulted and drives TX requests.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   OK     | no candidate fault sequence seen within the column window
//   COUNT  | counting same-type sequences toward the fault threshold
//   FAULT  | fault declared; held while sequences keep arriving in window
module xgmii_rx_link_fault_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int COL_WINDOW = 128,
    parameter int SEQ_THRESH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    xgmii_rx_link_fault_ctrl_if.slave     xgmii,
    input  logic                          cfg_gate_enable,
    input  logic                          clear_count,
    output logic                          tx_send_remote_fault,
    output logic                          tx_send_idle,
    output logic                          status_link_ok,
    output logic                          status_local_fault,
    output logic                          status_remote_fault,
    output logic [CNT_WIDTH-1:0]          fault_event_count
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("xgmii_rx_link_fault_ctrl supports DATA_WIDTH == 32 only");
    end
    if (COL_WINDOW < 2 || COL_WINDOW > 256 || SEQ_THRESH < 2 || SEQ_THRESH > 7) begin : g_bad_cfg
        $error("xgmii_rx_link_fault_ctrl: COL_WINDOW or SEQ_THRESH out of range");
    end

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [1:0] LF_NONE   = 2'd0;
    localparam logic [1:0] LF_LOCAL  = 2'd1;
    localparam logic [1:0] LF_REMOTE = 2'd2;

    localparam logic [7:0]            COL_LAST  = 8'(COL_WINDOW - 1);
    localparam logic [2:0]            THRESH    = 3'(SEQ_THRESH);
    localparam logic [DATA_WIDTH-1:0] IDLE_RXD  = 32'h07070707;
    localparam logic [CTRL_WIDTH-1:0] IDLE_RXC  = {CTRL_WIDTH{1'b1}};

    logic [1:0]            state_q, state_d;
    logic                  last_type_q, last_type_d;
    logic [2:0]            seq_cnt_q, seq_cnt_d;
    logic [7:0]            col_cnt_q, col_cnt_d;
    logic [1:0]            link_fault_q, link_fault_d;
    logic [DATA_WIDTH-1:0] rxd_out_q, rxd_out_d;
    logic [CTRL_WIDTH-1:0] rxc_out_q, rxc_out_d;
    logic [4:0]            status_q, status_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic                  is_seq;
    logic                  seq_type;
    logic [1:0]            seq_lf;
    logic                  gate;

    // lane0 is rxd[7:0]; lane3 carries the fault type
    always_comb begin
        seq_type = (xgmii.xgmii_rxd_in[31:24] == 8'h02);
        is_seq   = (xgmii.xgmii_rxc_in == CTRL_WIDTH'(1)) &&
                   (xgmii.xgmii_rxd_in[23:0] == 24'h00009C) &&
                   (xgmii.xgmii_rxd_in[31:24] == 8'h01 || xgmii.xgmii_rxd_in[31:24] == 8'h02);
        seq_lf   = seq_type ? LF_REMOTE : LF_LOCAL;
    end

    always_comb begin
        state_d      = state_q;
        last_type_d  = last_type_q;
        seq_cnt_d    = seq_cnt_q;
        col_cnt_d    = col_cnt_q;
        link_fault_d = link_fault_q;
        case (state_q)
            ST_OK: begin
                if (is_seq) begin
                    last_type_d = seq_type;
                    seq_cnt_d   = 3'd1;
                    col_cnt_d   = 8'd0;
                    state_d     = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (is_seq) begin
                    col_cnt_d = 8'd0;
                    if (seq_type == last_type_q) begin
                        seq_cnt_d = seq_cnt_q + 3'd1;
                        if (seq_cnt_q + 3'd1 == THRESH) begin
                            link_fault_d = seq_lf;
                            state_d      = ST_FAULT;
                        end
                    end else begin
                        last_type_d = seq_type;
                        seq_cnt_d   = 3'd1;
                    end
                end else if (col_cnt_q == COL_LAST) begin
                    // a prior fault that was being re-qualified also ends here
                    col_cnt_d    = 8'd0;
                    seq_cnt_d    = 3'd0;
                    link_fault_d = LF_NONE;
                    state_d      = ST_OK;
                end else begin
                    col_cnt_d = col_cnt_q + 8'd1;
                end
            end
            ST_FAULT: begin
                if (is_seq) begin
                    col_cnt_d = 8'd0;
                    if (seq_type != last_type_q) begin
                        last_type_d = seq_type;
                        seq_cnt_d   = 3'd1;
                        state_d     = ST_COUNT;
                    end
                end else if (col_cnt_q == COL_LAST) begin
                    col_cnt_d    = 8'd0;
                    seq_cnt_d    = 3'd0;
                    link_fault_d = LF_NONE;
                    state_d      = ST_OK;
                end else begin
                    col_cnt_d = col_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d      = ST_OK;
                seq_cnt_d    = 3'd0;
                col_cnt_d    = 8'd0;
                link_fault_d = LF_NONE;
            end
        endcase
    end

    always_comb begin
        gate      = cfg_gate_enable && (link_fault_q != LF_NONE);
        rxd_out_d = gate ? IDLE_RXD : xgmii.xgmii_rxd_in;
        rxc_out_d = gate ? IDLE_RXC : xgmii.xgmii_rxc_in;

        // {link_ok, local, remote, tx_remote_fault, tx_idle}
        status_d = {link_fault_d == LF_NONE, link_fault_d == LF_LOCAL, link_fault_d == LF_REMOTE,
                    link_fault_d == LF_LOCAL, link_fault_d == LF_REMOTE};

        count_d = count_q;
        if (clear_count) begin
            count_d = '0;
        end else if (link_fault_q == LF_NONE && link_fault_d != LF_NONE && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OK;
            last_type_q  <= 1'b0;
            seq_cnt_q    <= 3'd0;
            col_cnt_q    <= 8'd0;
            link_fault_q <= LF_NONE;
            rxd_out_q    <= IDLE_RXD;
            rxc_out_q    <= IDLE_RXC;
            status_q     <= 5'b10000;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_type_q  <= last_type_d;
            seq_cnt_q    <= seq_cnt_d;
            col_cnt_q    <= col_cnt_d;
            link_fault_q <= link_fault_d;
            rxd_out_q    <= rxd_out_d;
            rxc_out_q    <= rxc_out_d;
            status_q     <= status_d;
            count_q      <= count_d;
        end
    end

    assign xgmii.xgmii_rxd_out  = rxd_out_q;
    assign xgmii.xgmii_rxc_out  = rxc_out_q;
    assign status_link_ok       = status_q[4];
    assign status_local_fault   = status_q[3];
    assign status_remote_fault  = status_q[2];
    assign tx_send_remote_fault = status_q[1];
    assign tx_send_idle         = status_q[0];
    assign fault_event_count    = count_q;

endmodule
